rgb2bayer: RTL and testbench
============================

Name: rgb2bayer

Overview:
- Re-mosaics a raster-order 24-bit RGB pixel stream into an 8-bit Bayer raw stream. It is the inverse of bayer2rgb.
- Sits in front of bayer2rgb in loopback benches, so synthetic RGB frames can be turned into RGGB/BGGR/GRBG/GBRG raw data on chip.
- Tracks row/column position per frame, latches the CFA pattern at start of frame, and emits a registered output with frame/line markers.

Parameters:
IMG_WIDTH, 320, active pixels per line (>=2, even)
IMG_HEIGHT, 466, active lines per frame (>=2, even)
BLACK_LEVEL, 8'd0, offset added to every output sample when RGB2BAYER_BLC_EN is defined (8 bits)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
data_valid  input  1  r_in/g_in/b_in carry one pixel this cycle
r_in  input  8  red component
g_in  input  8  green component
b_in  input  8  blue component
pattern_select  input  2  00 RGGB, 01 BGGR, 10 GRBG, 11 GBRG
data_out_valid  output  1  bayer_data valid
bayer_data  output  8  selected raw sample
sof_out  output  1  qualifies first output pixel of frame
eol_out  output  1  qualifies last output pixel of each line
eof_out  output  1  qualifies last output pixel of frame
busy  output  1  high while a frame is partially received

Behaviour:
- Reset values (asserted on any clk edge with rst=1):
  - data_out_valid=0, bayer_data=0, sof_out=0, eol_out=0, eof_out=0, busy=0.
  - col_cnt=0, row_cnt=0, latched pattern=00, state=IDLE.
- Column and row counters:
  - col_cnt spans 0..IMG_WIDTH-1; row_cnt spans 0..IMG_HEIGHT-1.
  - Both advance only on data_valid=1.
  - Gaps (data_valid=0) hold all state; there is no timeout.
- State machine:
  - IDLE: on data_valid, latch pattern_select into pat_q and go to ACTIVE. The same pixel is processed as (row 0, col 0) using the newly sampled pattern_select.
  - ACTIVE: accept pixels. On the accepted pixel with col_cnt=IMG_WIDTH-1 and row_cnt=IMG_HEIGHT-1, clear both counters and return to IDLE.
  - busy = (state==ACTIVE).
- Pattern handling: pattern_select changes while ACTIVE are ignored until the next frame.
- Colour selection by (row parity rp, col parity cp):
  - RGGB: (0,0)=R, (0,1)=G, (1,0)=G, (1,1)=B.
  - BGGR: swap R and B relative to RGGB.
  - GRBG: (0,0)=G, (0,1)=R, (1,0)=B, (1,1)=G.
  - GBRG: swap R and B relative to GRBG.
- Latency and output timing:
  - Exactly 1 cycle: outputs are registered at the edge after the input pixel.
  - data_out_valid mirrors data_valid delayed by 1 cycle.
  - When data_out_valid=0, bayer_data holds its last value and all markers are 0.
- Markers, registered with the pixel:
  - sof_out: col=0 and row=0.
  - eol_out: col=IMG_WIDTH-1.
  - eof_out: col=IMG_WIDTH-1 and row=IMG_HEIGHT-1. eol_out is also 1 on that pixel.
- Throughput: 1 pixel/cycle sustained. Back-to-back frames need no idle cycle; the IDLE->ACTIVE transition happens on the first pixel of the next frame.
- Reset mid-frame: the frame is abandoned, all state returns to reset values, and the next valid pixel is treated as (0,0) of a new frame.

Optional Feature:
- RGB2BAYER_BLC_EN defined:
  - bayer_data = min(selected + BLACK_LEVEL, 255), using a 9-bit sum with saturation.
  - Latency is unchanged (still 1 cycle).
- Not defined: bayer_data = selected component unmodified; BLACK_LEVEL is unused.

Test Plan:
- All tests use IMG_WIDTH=4, IMG_HEIGHT=2.
- Reset, then stream 8 pixels of r=0x10, g=0x20, b=0x30 with pattern 00 -> bayer_data sequence 10,20,10,20,20,30,20,30, starting one cycle after the first data_valid. sof_out on output 0, eol_out on outputs 3 and 7, eof_out on output 7; busy drops the cycle after the last input.
- Repeat the same stream with patterns 01, 10, 11 -> 30,20,30,20,20,10,20,10 / 20,10,20,10,30,20,30,20 / 20,30,20,30,10,20,10,20.
- Pattern 00 at frame start, switch pattern_select to 01 after pixel 2 -> the whole frame stays RGGB; the next frame uses BGGR.
- Insert random data_valid=0 gaps of 1-5 cycles -> identical output sequence, data_out_valid only on accepted pixels, markers unaffected.
- Assert rst for 1 cycle after pixel 5, then send a fresh frame -> no data_out_valid during the rst cycle; new frame starts with sof_out and correct (0,0) colour.
- RGB2BAYER_BLC_EN with BLACK_LEVEL=0x20, r=0xF0, pattern 00 -> pixel (0,0)=0xFF (saturated); g=0x20 gives 0x40.

Source files
------------

// File: rtl/rgb2bayer.sv
// RGB-to-Bayer re-mosaic: picks one colour component per pixel from the CFA pattern latched at frame start.
// Optional macro RGB2BAYER_BLC_EN adds a saturating BLACK_LEVEL offset to every output sample.
module rgb2bayer #(
    parameter int         IMG_WIDTH   = 320,
    parameter int         IMG_HEIGHT  = 466,
    parameter logic [7:0] BLACK_LEVEL = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic [1:0] pattern_select,
    output logic       data_out_valid,
    output logic [7:0] bayer_data,
    output logic       sof_out,
    output logic       eol_out,
    output logic       eof_out,
    output logic       busy
);
    localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [1:0]    pat_q;
    logic [1:0]    pat_cur;
    logic          col_last, row_last, frame_last;
    logic          is_green, is_red;
    logic [7:0]    selected, sample;

    assign col_last   = (col_cnt == COL_LAST);
    assign row_last   = (row_cnt == ROW_LAST);
    assign frame_last = col_last && row_last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (data_valid) state_next = ACTIVE;
            ACTIVE:  if (data_valid && frame_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The first pixel of a frame uses pattern_select directly, before pat_q has captured it.
    always_comb begin
        busy     = (state == ACTIVE);
        pat_cur  = (state == IDLE) ? pattern_select : pat_q;
        // pat[1] moves green off the diagonal, pat[0] swaps red and blue.
        is_green = row_cnt[0] ^ col_cnt[0] ^ pat_cur[1];
        is_red   = ~row_cnt[0] ^ pat_cur[0];
        if (is_green)    selected = g_in;
        else if (is_red) selected = r_in;
        else             selected = b_in;
    end

`ifdef RGB2BAYER_BLC_EN
    logic [8:0] blc_sum;
    assign blc_sum = {1'b0, selected} + {1'b0, BLACK_LEVEL};
    assign sample  = blc_sum[8] ? 8'hFF : blc_sum[7:0];
`else
    assign sample  = selected;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt        <= '0;
            row_cnt        <= '0;
            pat_q          <= 2'b00;
            data_out_valid <= 1'b0;
            bayer_data     <= 8'd0;
            sof_out        <= 1'b0;
            eol_out        <= 1'b0;
            eof_out        <= 1'b0;
        end else begin
            data_out_valid <= data_valid;
            sof_out        <= data_valid && (col_cnt == '0) && (row_cnt == '0);
            eol_out        <= data_valid && col_last;
            eof_out        <= data_valid && frame_last;
            if (data_valid) begin
                bayer_data <= sample;
                if (state == IDLE) pat_q <= pattern_select;
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rgb2bayer.sv
// Scoreboard bench for rgb2bayer at 4x2; driver pushes expected samples, negedge monitor pops and compares.
module tb_rgb2bayer;
    localparam int W = 4;
    localparam int H = 2;
    localparam logic [7:0] BL = 8'h20;

    typedef struct {
        logic [7:0] data;
        logic       sof, eol, eof, busy;
    } exp_t;

    logic       clk = 0, rst = 1, data_valid = 0;
    logic [7:0] r_in = 0, g_in = 0, b_in = 0;
    logic [1:0] pattern_select = 0;
    logic       data_out_valid, sof_out, eol_out, eof_out, busy;
    logic [7:0] bayer_data;

    rgb2bayer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BLACK_LEVEL(BL)) dut (
        .clk(clk), .rst(rst), .data_valid(data_valid),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .pattern_select(pattern_select),
        .data_out_valid(data_out_valid), .bayer_data(bayer_data),
        .sof_out(sof_out), .eol_out(eol_out), .eof_out(eof_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    exp_t q[$];
    logic mon_en = 0;
    logic [7:0] last_data = 0;
    logic       last_busy = 0;
    int   m_row = 0, m_col = 0;
    logic [1:0] m_pat = 0;
    logic m_active = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pick(input logic [1:0] pat, input int rp, input int cp,
                                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [7:0] v;
        logic [8:0] s;
        case (pat)
            2'b00: v = (rp == 0) ? ((cp == 0) ? r : g) : ((cp == 0) ? g : b);
            2'b01: v = (rp == 0) ? ((cp == 0) ? b : g) : ((cp == 0) ? g : r);
            2'b10: v = (rp == 0) ? ((cp == 0) ? g : r) : ((cp == 0) ? b : g);
            default: v = (rp == 0) ? ((cp == 0) ? g : b) : ((cp == 0) ? r : g);
        endcase
`ifdef RGB2BAYER_BLC_EN
        s = {1'b0, v} + {1'b0, BL};
        v = (s > 9'd255) ? 8'hFF : s[7:0];
`else
        s = 9'd0;
`endif
        return v;
    endfunction

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic [1:0] psel);
        exp_t e;
        r_in = r; g_in = g; b_in = b; pattern_select = psel; data_valid = 1;
        if (!m_active) begin
            m_pat = psel; m_active = 1; m_row = 0; m_col = 0;
        end
        e.data = pick(m_pat, m_row % 2, m_col % 2, r, g, b);
        e.sof  = (m_row == 0) && (m_col == 0);
        e.eol  = (m_col == W - 1);
        e.eof  = (m_col == W - 1) && (m_row == H - 1);
        if (m_col == W - 1) begin
            m_col = 0;
            if (m_row == H - 1) begin m_row = 0; m_active = 0; end
            else m_row++;
        end else m_col++;
        e.busy = m_active;
        q.push_back(e);
        @(posedge clk); #1;
        data_valid = 0;
    endtask

    task automatic gap(input int n);
        data_valid = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1; data_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        m_row = 0; m_col = 0; m_pat = 0; m_active = 0;
        last_data = 0; last_busy = 0;
    endtask

    task automatic frame(input logic [1:0] p, input bit gaps);
        for (int i = 0; i < W * H; i++) begin
            send(8'h10, 8'h20, 8'h30, p);
            if (gaps) gap($urandom_range(5, 1));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (data_out_valid === 1'b1) begin
                if (q.size() == 0) chk("q_underflow", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data", bayer_data, e.data);
                    chk("sof", sof_out, e.sof);
                    chk("eol", eol_out, e.eol);
                    chk("eof", eof_out, e.eof);
                    chk("busy", busy, e.busy);
                    last_data = e.data;
                    last_busy = e.busy;
                end
            end else begin
                chk("idle_valid", data_out_valid, 0);
                chk("idle_hold", bayer_data, last_data);
                chk("idle_marks", {sof_out, eol_out, eof_out}, 0);
                chk("idle_busy", busy, last_busy);
            end
        end
    end

    initial begin
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1;
        gap(2);
        // Back-to-back frames for all four patterns
        for (int p = 0; p < 4; p++) frame(p[1:0], 0);
        gap(3);
        // Mid-frame pattern change is ignored until next frame
        for (int i = 0; i < W * H; i++) send(8'h10, 8'h20, 8'h30, (i < 2) ? 2'b00 : 2'b01);
        frame(2'b01, 0);
        gap(2);
        frame(2'b10, 1);
        frame(2'b11, 1);
        // Abandon a frame with reset after 5 pixels
        for (int i = 0; i < 5; i++) send(8'h10, 8'h20, 8'h30, 2'b00);
        do_reset();
        gap(1);
        frame(2'b10, 0);
        gap(2);
        // Saturation corner with large red
        for (int i = 0; i < W * H; i++) send(8'hF0, 8'h20, 8'h30, 2'b00);
        gap(4);
        chk("q_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
